neuron_writeback: RTL and testbench

NEURON_WRITEBACK -- requirements
Module: neuron_writeback

---
 rtl/neuron_writeback_if.sv | 22 ++
 rtl/neuron_writeback.sv | 135 +++++++++++++
 tb/tb_neuron_writeback.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_writeback_if.sv
// Activation stream and cache write port of the neuron writeback stage.
// The master is the surrounding datapath; the slave is the writeback unit.
interface neuron_writeback_if;
    logic       act_valid_i;
    logic [7:0] act_data_i;
    logic       act_ready_o;
    logic       cache_hold_i;
    logic       cache_wr_o;
    logic [2:0] channel_sel_o;
    logic [4:0] address_o;
    logic [7:0] cache_data_o;

    modport master (
        output act_valid_i, act_data_i, cache_hold_i,
        input  act_ready_o, cache_wr_o, channel_sel_o, address_o, cache_data_o
    );

    modport slave (
        input  act_valid_i, act_data_i, cache_hold_i,
        output act_ready_o, cache_wr_o, channel_sel_o, address_o, cache_data_o
    );
endinterface

// File: rtl/neuron_writeback.sv
// Buffers a layer's activations and writes them to the cache column by column,
// rotating across the cache channels; one write per cycle when not stalled.
module neuron_writeback #(
    parameter int CHANNELS   = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              layer_reset,
    input  logic              writeback_en_i,
    input  logic [4:0]        picture_height_i,
    input  logic [7:0]        column_count_i,
    neuron_writeback_if.slave bus,
    output logic              column_done_o,
    output logic              layer_done_o
);
    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [2:0]     CH_LAST = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [4:0]     row_last;
    logic [7:0]     col_last;
    logic [4:0]     acc_row;
    logic [7:0]     acc_col;
    logic           acc_all;
    logic [4:0]     wr_row;
    logic [7:0]     wr_col;
    logic [2:0]     wr_ch;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           fifo_full, fifo_empty;
    logic           act_ready, accept, issue, last_row, last_write;
    logic           cache_wr_q, column_done_q;
    logic [2:0]     channel_q;
    logic [4:0]     address_q;
    logic [7:0]     data_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign act_ready  = (state == S_WRITE) && writeback_en_i && !fifo_full && !acc_all;
    assign accept     = bus.act_valid_i && act_ready;
    assign issue      = (state == S_WRITE) && writeback_en_i && !fifo_empty && !bus.cache_hold_i;
    assign last_row   = (wr_row == row_last);
    assign last_write = last_row && (wr_col == col_last);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (writeback_en_i) state_nxt = S_WRITE;
            S_WRITE: if (issue && last_write) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[PTR_W-1:0]] <= bus.act_data_i;
    end

    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            row_last      <= '0;
            col_last      <= '0;
            acc_row       <= '0;
            acc_col       <= '0;
            acc_all       <= 1'b0;
            wr_row        <= '0;
            wr_col        <= '0;
            wr_ch         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cache_wr_q    <= 1'b0;
            column_done_q <= 1'b0;
            channel_q     <= '0;
            address_q     <= '0;
            data_q        <= '0;
        end else begin
            // Stored as last index so 0 naturally encodes the full range.
            if (state == S_IDLE && writeback_en_i) begin
                row_last <= picture_height_i - 5'd1;
                col_last <= column_count_i - 8'd1;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (acc_row == row_last) begin
                    acc_row <= '0;
                    if (acc_col == col_last) acc_all <= 1'b1;
                    else                     acc_col <= acc_col + 8'd1;
                end else begin
                    acc_row <= acc_row + 5'd1;
                end
            end

            cache_wr_q    <= issue;
            column_done_q <= 1'b0;
            if (issue) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                channel_q     <= wr_ch;
                address_q     <= wr_row;
                data_q        <= mem[rd_ptr[PTR_W-1:0]];
                column_done_q <= last_row;
                if (last_row) begin
                    wr_row <= '0;
                    wr_col <= wr_col + 8'd1;
                    wr_ch  <= (wr_ch == CH_LAST) ? 3'd0 : wr_ch + 3'd1;
                end else begin
                    wr_row <= wr_row + 5'd1;
                end
            end
        end
    end

    assign bus.act_ready_o   = act_ready;
    assign bus.cache_wr_o    = cache_wr_q;
    assign bus.channel_sel_o = channel_q;
    assign bus.address_o     = address_q;
    assign bus.cache_data_o  = data_q;
    assign column_done_o     = column_done_q;
    assign layer_done_o      = (state == S_DONE);
endmodule

// File: tb/tb_neuron_writeback.sv
// Scoreboard bench for neuron_writeback: each accepted activation queues its
// expected cache write, and a negedge monitor pops and compares every write.
module tb_neuron_writeback;
    localparam int CHANNELS   = 7;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       layer_reset;
    logic       writeback_en_i;
    logic [4:0] picture_height_i;
    logic [7:0] column_count_i;
    logic       column_done_o;
    logic       layer_done_o;

    neuron_writeback_if bus();

    neuron_writeback #(.CHANNELS(CHANNELS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk              (clk),
        .layer_reset      (layer_reset),
        .writeback_en_i   (writeback_en_i),
        .picture_height_i (picture_height_i),
        .column_count_i   (column_count_i),
        .bus              (bus),
        .column_done_o    (column_done_o),
        .layer_done_o     (layer_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ch;
        logic [4:0] addr;
        logic [7:0] data;
        logic       col_done;
    } wr_t;

    wr_t  sb[$];
    wr_t  exp_w;
    int   checks = 0, failures = 0;
    int   m_h, m_c, m_row, m_col, m_acc;
    int   cyc = 0, n_writes = 0, n_coldone = 0, last_wr_cyc = -1, max_gap = 0;
    logic cur_en = 1'b0, cur_hold = 1'b0, cur_valid = 1'b0;
    logic [7:0] cur_data = '0;

    function automatic logic [19:0] out_vec();
        return {bus.act_ready_o, bus.cache_wr_o, bus.channel_sel_o, bus.address_o,
                bus.cache_data_o, column_done_o, layer_done_o};
    endfunction

    // Every write the DUT registers is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (!layer_reset) begin
            cyc++;
            if (bus.cache_wr_o === 1'b1) begin
                n_writes++;
                if (last_wr_cyc >= 0 && cyc - last_wr_cyc > max_gap) max_gap = cyc - last_wr_cyc;
                last_wr_cyc = cyc;
                if (column_done_o === 1'b1) n_coldone++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write ch=%0d addr=%0d data=%0h with empty scoreboard",
                             bus.channel_sel_o, bus.address_o, bus.cache_data_o);
                end else begin
                    exp_w = sb.pop_front();
                    if ({bus.channel_sel_o, bus.address_o, bus.cache_data_o, column_done_o} !== exp_w) begin
                        failures++;
                        $display("FAIL write got ch=%0d addr=%0d data=%0h cd=%0b want ch=%0d addr=%0d data=%0h cd=%0b",
                                 bus.channel_sel_o, bus.address_o, bus.cache_data_o, column_done_o,
                                 exp_w.ch, exp_w.addr, exp_w.data, exp_w.col_done);
                    end
                end
            end else if (column_done_o !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL column_done_without_write got=%b want=0", column_done_o);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: drive at the negedge, then record whether the next edge accepts.
    task automatic cycle(output bit acc);
        @(negedge clk);
        writeback_en_i   = cur_en;
        bus.cache_hold_i = cur_hold;
        bus.act_valid_i  = cur_valid;
        bus.act_data_i   = cur_data;
        #1;
        acc = cur_valid && (bus.act_ready_o === 1'b1);
        if (acc) begin
            sb.push_back(wr_t'{ch: 3'(m_col % CHANNELS), addr: 5'(m_row), data: cur_data,
                               col_done: (m_row == m_h - 1)});
            m_acc++;
            if (m_row == m_h - 1) begin
                m_row = 0;
                m_col++;
            end else begin
                m_row++;
            end
        end
    endtask

    task automatic apply_reset();
        layer_reset = 1'b1;
        cur_en = 1'b0; cur_hold = 1'b0; cur_valid = 1'b0; cur_data = '0;
        writeback_en_i = 1'b0; bus.act_valid_i = 1'b0; bus.cache_hold_i = 1'b0; bus.act_data_i = '0;
        picture_height_i = '0; column_count_i = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        layer_reset = 1'b0;
    endtask

    task automatic start_layer(input logic [4:0] h, input logic [7:0] c);
        bit acc;
        m_h = (h == 0) ? 32 : int'(h);
        m_c = (c == 0) ? 256 : int'(c);
        m_row = 0; m_col = 0; m_acc = 0;
        picture_height_i = h;
        column_count_i   = c;
        cur_en = 1'b1; cur_valid = 1'b0;
        cycle(acc);
        cycle(acc);
        n_writes = 0; n_coldone = 0; last_wr_cyc = -1; max_gap = 0;
    endtask

    task automatic stream(input int n, input bit rnd);
        int got = 0;
        bit acc;
        cur_valid = 1'b1;
        cur_data  = rnd ? 8'($urandom) : 8'(m_acc);
        for (int k = 0; k < n * 4 + 20 && got < n; k++) begin
            cycle(acc);
            if (acc) begin
                got++;
                cur_data = rnd ? 8'($urandom) : 8'(m_acc);
            end
        end
        cur_valid = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL stream_accepts got=%0d want=%0d", got, n);
        end
    endtask

    task automatic drain();
        bit acc;
        cur_valid = 1'b0;
        for (int k = 0; k < 60 && sb.size() != 0; k++) cycle(acc);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
        end
    endtask

    task automatic test_reset();
        bit acc;
        layer_reset = 1'b1;
        writeback_en_i = 1'b0; bus.act_valid_i = 1'b0; bus.cache_hold_i = 1'b0; bus.act_data_i = '0;
        picture_height_i = '0; column_count_i = '0;
        #1;
        checks++;
        if (out_vec() !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", out_vec());
        end
        apply_reset();
        cur_valid = 1'b1; cur_data = 8'hA5;
        repeat (3) cycle(acc);
        cur_valid = 1'b0;
        checks++;
        if (out_vec() !== 20'd0 || acc) begin
            failures++;
            $display("FAIL idle_outputs got=%h accept=%0b want=0", out_vec(), acc);
        end
    endtask

    task automatic test_full_column();
        apply_reset();
        start_layer(5'd0, 8'd1);
        stream(32, 1'b0);
        drain();
        checks++;
        if (n_writes != 32 || n_coldone != 1) begin
            failures++;
            $display("FAIL full_column_counts writes=%0d coldone=%0d want 32/1", n_writes, n_coldone);
        end
        checks++;
        if (max_gap != 1) begin
            failures++;
            $display("FAIL full_column_back_to_back max_gap=%0d want=1", max_gap);
        end
        checks++;
        if (layer_done_o !== 1'b1 || bus.act_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL full_column_done layer_done=%b ready=%b want 1/0", layer_done_o, bus.act_ready_o);
        end
    endtask

    task automatic test_channel_rotation();
        int extra = 0;
        bit acc;
        apply_reset();
        start_layer(5'd3, 8'd9);
        picture_height_i = 5'd5;
        column_count_i   = 8'd2;
        stream(27, 1'b1);
        cur_valid = 1'b1;
        repeat (5) begin
            cycle(acc);
            extra += int'(acc);
        end
        cur_valid = 1'b0;
        checks++;
        if (extra != 0 || bus.act_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rotation_ready_after_last extra_accepts=%0d ready=%b want 0/0", extra, bus.act_ready_o);
        end
        drain();
        checks++;
        if (n_writes != 27 || n_coldone != 9) begin
            failures++;
            $display("FAIL rotation_counts writes=%0d coldone=%0d want 27/9", n_writes, n_coldone);
        end
        checks++;
        if (layer_done_o !== 1'b1) begin
            failures++;
            $display("FAIL rotation_layer_done got=%b want=1", layer_done_o);
        end
    endtask

    task automatic test_hold();
        int acc_cnt = 0, w0;
        bit acc;
        apply_reset();
        start_layer(5'd8, 8'd2);
        stream(3, 1'b1);
        drain();
        w0 = n_writes;
        cur_hold = 1'b1; cur_valid = 1'b1;
        repeat (10) begin
            cycle(acc);
            acc_cnt += int'(acc);
        end
        checks++;
        if (acc_cnt != FIFO_DEPTH || bus.act_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_accepts got=%0d ready=%b want %0d/0", acc_cnt, bus.act_ready_o, FIFO_DEPTH);
        end
        checks++;
        if (n_writes != w0) begin
            failures++;
            $display("FAIL hold_writes got=%0d want=0", n_writes - w0);
        end
        cur_hold = 1'b0;
        last_wr_cyc = -1; max_gap = 0;
        stream(9, 1'b1);
        drain();
        checks++;
        if (max_gap != 1 || n_writes != 16) begin
            failures++;
            $display("FAIL hold_resume max_gap=%0d writes=%0d want 1/16", max_gap, n_writes);
        end
        checks++;
        if (layer_done_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_layer_done got=%b want=1", layer_done_o);
        end
    endtask

    task automatic test_enable_pause();
        int acc_cnt, w0;
        bit acc;
        apply_reset();
        start_layer(5'd10, 8'd1);
        stream(4, 1'b1);
        cur_en = 1'b0; cur_valid = 1'b1;
        cycle(acc);
        acc_cnt = int'(acc);
        w0 = n_writes;
        repeat (4) begin
            cycle(acc);
            acc_cnt += int'(acc);
        end
        checks++;
        if (acc_cnt != 0 || n_writes != w0) begin
            failures++;
            $display("FAIL pause_activity accepts=%0d writes=%0d want 0/0", acc_cnt, n_writes - w0);
        end
        checks++;
        if (bus.address_o !== 5'd2 || bus.cache_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold addr=%0d wr=%b want 2/0", bus.address_o, bus.cache_wr_o);
        end
        cur_en = 1'b1;
        stream(6, 1'b1);
        drain();
        checks++;
        if (n_writes != 10 || layer_done_o !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume writes=%0d layer_done=%b want 10/1", n_writes, layer_done_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start_layer(5'd4, 8'd3);
        stream(6, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (bus.cache_wr_o !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_write got=%b want=1", bus.cache_wr_o);
        end
        layer_reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== 20'd0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h want=0", out_vec());
        end
        apply_reset();
        start_layer(5'd2, 8'd1);
        stream(2, 1'b1);
        drain();
        checks++;
        if (n_writes != 2 || layer_done_o !== 1'b1) begin
            failures++;
            $display("FAIL async_restart writes=%0d layer_done=%b want 2/1", n_writes, layer_done_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_column();
        test_channel_rotation();
        test_hold();
        test_enable_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
